dma_reg_arbiter: RTL and testbench

Round-robin arbiter that shares the single DMA register-access bus (wr_en/rd_en/addr/wdata/rdata) among NUM_REQ requesters, such as host configuration and the descriptor-fetch engine. Each requester issues one access at a time through a valid/ready handshake. The arbiter sequences the winning access onto the register bus and returns completion plus read data to that requester. It sits between the requesters and the DMA register file, and the register-bus driver/monitor agents attach on its downstream side.

---
 rtl/dma_reg_arbiter.sv | 101 ++++++++++
 tb/tb_dma_reg_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dma_reg_arbiter.sv
// dma_reg_arbiter: round-robin arbiter sharing one register-access bus among NUM_REQ requesters
module dma_reg_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    input  logic [NUM_REQ-1:0]    req_write,
    input  logic [NUM_REQ*AW-1:0] req_addr,
    input  logic [NUM_REQ*DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]    req_ready,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]         rsp_rdata,
    output logic                  busy,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [AW-1:0]         addr,
    output logic [DW-1:0]         wdata,
    input  logic [DW-1:0]         rdata
);
    localparam int GW = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t               state_q, state_d;
    logic [GW-1:0]        last_gnt_q, last_gnt_d, gnt, idx;
    logic                 found;
    logic                 write_q, write_d, wr_en_q, wr_en_d, rd_en_q, rd_en_d;
    logic [AW-1:0]        addr_q, addr_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
    // search starts one past the last grant so every requester gets its turn
    always_comb begin
        gnt   = last_gnt_q;
        idx   = last_gnt_q;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = GW'((int'(last_gnt_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                gnt   = idx;
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        write_d     = write_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wr_en_d     = 1'b0;
        rd_en_d     = 1'b0;
        rsp_valid_d = '0;
        req_ready   = '0;
        case (state_q)
            IDLE: if (found) begin
                state_d    = ISSUE;
                last_gnt_d = gnt;
                write_d    = req_write[gnt];
                addr_d     = req_addr[gnt*AW +: AW];
                wdata_d    = req_wdata[gnt*DW +: DW];
                wr_en_d    = req_write[gnt];
                rd_en_d    = !req_write[gnt];
                req_ready  = {NUM_REQ{!rst}} & (NUM_REQ'(1) << gnt);
            end
            ISSUE: begin
                state_d     = RESP;
                rsp_valid_d = NUM_REQ'(1) << last_gnt_q;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_gnt_q  <= GW'(NUM_REQ - 1);
            write_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= '0;
        end else begin
            state_q     <= state_d;
            last_gnt_q  <= last_gnt_d;
            write_q     <= write_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = (|rsp_valid_q && !write_q) ? rdata : '0;
    assign busy      = state_q != IDLE;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign addr      = addr_q;
    assign wdata     = wdata_q;
endmodule

// File: tb/tb_dma_reg_arbiter.sv
// tb_dma_reg_arbiter: directed checks of grant order, bus timing and reset abort
module tb_dma_reg_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]  v2 = '0, w2 = '0, rdy2, rsp2;
    logic [63:0] a2 = '0, d2 = '0;
    logic [31:0] rsd2, ba2, bw2, br2 = '0;
    logic        busy2, wr2, rd2;
    logic [2:0]  v3 = '0, w3 = '0, rdy3, rsp3;
    logic [95:0] a3 = '0, d3 = '0;
    logic [31:0] rsd3, ba3, bw3, br3 = '0;
    logic        busy3, wr3, rd3;

    dma_reg_arbiter #(.NUM_REQ(2), .AW(32), .DW(32)) dut2 (
        .clk(clk), .rst(rst), .req_valid(v2), .req_write(w2), .req_addr(a2), .req_wdata(d2),
        .req_ready(rdy2), .rsp_valid(rsp2), .rsp_rdata(rsd2), .busy(busy2),
        .wr_en(wr2), .rd_en(rd2), .addr(ba2), .wdata(bw2), .rdata(br2));
    dma_reg_arbiter #(.NUM_REQ(3), .AW(32), .DW(32)) dut3 (
        .clk(clk), .rst(rst), .req_valid(v3), .req_write(w3), .req_addr(a3), .req_wdata(d3),
        .req_ready(rdy3), .rsp_valid(rsp3), .rsp_rdata(rsd3), .busy(busy3),
        .wr_en(wr3), .rd_en(rd3), .addr(ba3), .wdata(bw3), .rdata(br3));

    // register model: read data appears the cycle after rd_en
    always @(posedge clk) begin
        if (rd2) br2 <= (ba2 == 32'h4) ? 32'hDEAD_BEEF : ba2 ^ 32'h1234_5678;
        if (rd3) br3 <= ba3 ^ 32'h1234_5678;
    end

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    int mon_err = 0;
    logic [1:0] pv2 = '0, pr2 = '0;
    logic [2:0] pv3 = '0, pr3 = '0;
    always @(negedge clk) begin
        if ((wr2 && rd2) || (wr3 && rd3) || ((rsp2 & (rsp2 - 2'd1)) != 0) || ((rsp3 & (rsp3 - 3'd1)) != 0)
            || (rdy2 != 0 && busy2) || (rdy3 != 0 && busy3) || ((rdy2 & (rdy2 - 2'd1)) != 0)
            || ((rdy3 & (rdy3 - 3'd1)) != 0)
            || (!rst && ((pv2 & ~pr2 & ~v2) != 0 || (pv3 & ~pr3 & ~v3) != 0))) begin
            $display("FAIL monitor at cycle %0d: wr2=%b rd2=%b rsp2=%b rdy2=%b wr3=%b rd3=%b rsp3=%b rdy3=%b v2=%b v3=%b",
                     cyc_n, wr2, rd2, rsp2, rdy2, wr3, rd3, rsp3, rdy3, v2, v3);
            mon_err <= mon_err + 1;
        end
        pv2 <= v2; pr2 <= rdy2; pv3 <= v3; pr3 <= rdy3;
    end

    int n_chk = 0, n_fail = 0;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        v2 = 2'b11; w2 = 2'b11; a2 = {32'h20, 32'h10}; d2 = {32'h2222_0002, 32'h1111_0001};
        repeat (2) cyc;
        #1;
        n_chk++; if (rdy2 !== 2'b00) begin n_fail++; $display("FAIL rst_ready got %b exp 00", rdy2); end
        n_chk++; if (busy2 !== 1'b0 || busy3 !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b/%b exp 0", busy2, busy3); end
        n_chk++; if ({wr2, rd2} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes got %b exp 00", {wr2, rd2}); end
        n_chk++; if (ba2 !== 32'h0 || bw2 !== 32'h0) begin n_fail++; $display("FAIL rst_bus got %h/%h exp 0", ba2, bw2); end
        n_chk++; if (rsp2 !== 2'b00 || rsd2 !== 32'h0) begin n_fail++; $display("FAIL rst_rsp got %b/%h exp 0", rsp2, rsd2); end
    endtask

    task automatic test_contention;
        int n, last, g;
        int rem[2];
        logic [1:0] exp;
        rem[0] = 2; rem[1] = 2; last = 0;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (rdy2 == 2'b00 && n < 8) begin cyc; n++; end
            g = i % 2;
            exp = 2'b01 << g;
            n_chk++; if (rdy2 !== exp) begin n_fail++; $display("FAIL contend_grant%0d got %b exp %b", i, rdy2, exp); end
            if (i > 0) begin
                n_chk++; if (cyc_n - last !== 3) begin n_fail++; $display("FAIL contend_gap%0d got %0d exp 3", i, cyc_n - last); end
            end
            last = cyc_n;
            cyc;
            rem[g]--;
            v2[g] = rem[g] != 0;
            #1;
            n_chk++; if (ba2 !== (g ? 32'h20 : 32'h10) || wr2 !== 1'b1) begin
                n_fail++; $display("FAIL contend_bus%0d got %h/%b exp %h/1", i, ba2, wr2, g ? 32'h20 : 32'h10); end
        end
        repeat (2) cyc;
    endtask

    task automatic test_single_write;
        v2 = 2'b01; w2 = 2'b01; a2[31:0] = 32'h0000_0010; d2[31:0] = 32'hA5A5_0001;
        #1;
        n_chk++; if (rdy2 !== 2'b01) begin n_fail++; $display("FAIL wr_ready got %b exp 01", rdy2); end
        cyc;
        v2 = 2'b00;
        #1;
        n_chk++; if ({wr2, rd2} !== 2'b10) begin n_fail++; $display("FAIL wr_strobe got %b exp 10", {wr2, rd2}); end
        n_chk++; if (ba2 !== 32'h10 || bw2 !== 32'hA5A5_0001) begin n_fail++; $display("FAIL wr_bus got %h/%h exp 00000010/a5a50001", ba2, bw2); end
        n_chk++; if (rdy2 !== 2'b00 || busy2 !== 1'b1) begin n_fail++; $display("FAIL wr_issue got rdy %b busy %b exp 00/1", rdy2, busy2); end
        cyc;
        n_chk++; if (rsp2 !== 2'b01 || rsd2 !== 32'h0 || wr2 !== 1'b0) begin
            n_fail++; $display("FAIL wr_rsp got %b/%h/%b exp 01/0/0", rsp2, rsd2, wr2); end
        cyc;
        n_chk++; if (rsp2 !== 2'b00 || busy2 !== 1'b0) begin n_fail++; $display("FAIL wr_done got %b/%b exp 00/0", rsp2, busy2); end
    endtask

    task automatic test_read;
        v2 = 2'b10; w2 = 2'b00; a2[63:32] = 32'h0000_0004;
        #1;
        n_chk++; if (rdy2 !== 2'b10) begin n_fail++; $display("FAIL rd_ready got %b exp 10", rdy2); end
        cyc;
        v2 = 2'b00;
        #1;
        n_chk++; if ({wr2, rd2} !== 2'b01 || ba2 !== 32'h4) begin n_fail++; $display("FAIL rd_strobe got %b/%h exp 01/4", {wr2, rd2}, ba2); end
        cyc;
        n_chk++; if (rsp2 !== 2'b10 || rsd2 !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rd_rsp got %b/%h exp 10/deadbeef", rsp2, rsd2); end
        cyc;
        n_chk++; if (rsp2 !== 2'b00 || rd2 !== 1'b0 || ba2 !== 32'h4) begin
            n_fail++; $display("FAIL rd_done got %b/%b/%h exp 00/0/4", rsp2, rd2, ba2); end
    endtask

    task automatic test_back_to_back;
        int n, last, g;
        int rem[2];
        logic [1:0] exp;
        rem[0] = 4; rem[1] = 4; last = 0;
        v2 = 2'b11; w2 = 2'b01; a2 = {32'h100, 32'h40}; d2[31:0] = 32'hC0DE_0000;
        #1;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            while (rdy2 == 2'b00 && n < 8) begin cyc; n++; end
            g = i % 2;
            exp = 2'b01 << g;
            n_chk++; if (rdy2 !== exp) begin n_fail++; $display("FAIL b2b_grant%0d got %b exp %b", i, rdy2, exp); end
            if (i > 0) begin
                n_chk++; if (cyc_n - last !== 3) begin n_fail++; $display("FAIL b2b_gap%0d got %0d exp 3", i, cyc_n - last); end
            end
            last = cyc_n;
            cyc;
            rem[g]--;
            v2[g] = rem[g] != 0;
            #1;
            n_chk++; if ({wr2, rd2} !== (g ? 2'b01 : 2'b10)) begin n_fail++; $display("FAIL b2b_strobe%0d got %b", i, {wr2, rd2}); end
            cyc;
            n_chk++; if (rsp2 !== exp || rsd2 !== (g ? 32'h1234_5778 : 32'h0)) begin
                n_fail++; $display("FAIL b2b_rsp%0d got %b/%h exp %b/%h", i, rsp2, rsd2, exp, g ? 32'h1234_5778 : 32'h0); end
        end
        cyc;
    endtask

    task automatic test_reset_during_issue;
        int n, g;
        logic [1:0] exp;
        v2 = 2'b11; w2 = 2'b11; a2 = {32'h84, 32'h80};
        #1;
        n_chk++; if (rdy2 !== 2'b01) begin n_fail++; $display("FAIL ab_ready got %b exp 01", rdy2); end
        cyc;
        n_chk++; if (wr2 !== 1'b1) begin n_fail++; $display("FAIL ab_issue got %b exp 1", wr2); end
        #1;
        rst = 1'b1;
        #1;
        n_chk++; if (wr2 !== 1'b0 || busy2 !== 1'b0 || ba2 !== 32'h0) begin
            n_fail++; $display("FAIL ab_async got wr %b busy %b addr %h exp 0/0/0", wr2, busy2, ba2); end
        cyc;
        n_chk++; if (rsp2 !== 2'b00) begin n_fail++; $display("FAIL ab_norsp got %b exp 00", rsp2); end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            n = 0;
            while (rdy2 == 2'b00 && n < 8) begin cyc; n++; end
            g = i;
            exp = 2'b01 << g;
            n_chk++; if (rdy2 !== exp) begin n_fail++; $display("FAIL ab_grant%0d got %b exp %b", i, rdy2, exp); end
            cyc;
            v2[g] = 1'b0;
            #1;
            n_chk++; if (ba2 !== (g ? 32'h84 : 32'h80)) begin n_fail++; $display("FAIL ab_addr%0d got %h", i, ba2); end
            cyc;
            n_chk++; if (rsp2 !== exp) begin n_fail++; $display("FAIL ab_rsp%0d got %b exp %b", i, rsp2, exp); end
        end
        cyc;
    endtask

    task automatic test_three_skip;
        int n, last, g;
        int rem[3];
        logic [2:0] exp;
        rem[0] = 2; rem[1] = 0; rem[2] = 2; last = 0;
        v3 = 3'b101; w3 = 3'b101; a3 = {32'h302, 32'h301, 32'h300};
        #1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (rdy3 == 3'b000 && n < 8) begin cyc; n++; end
            g = (i % 2) * 2;
            exp = 3'b001 << g;
            n_chk++; if (rdy3 !== exp) begin n_fail++; $display("FAIL three_grant%0d got %b exp %b", i, rdy3, exp); end
            if (i > 0) begin
                n_chk++; if (cyc_n - last !== 3) begin n_fail++; $display("FAIL three_gap%0d got %0d exp 3", i, cyc_n - last); end
            end
            last = cyc_n;
            cyc;
            rem[g]--;
            v3[g] = rem[g] != 0;
            #1;
            n_chk++; if (ba3 !== (g ? 32'h302 : 32'h300) || wr3 !== 1'b1) begin
                n_fail++; $display("FAIL three_bus%0d got %h/%b", i, ba3, wr3); end
            cyc;
            n_chk++; if (rsp3 !== exp) begin n_fail++; $display("FAIL three_rsp%0d got %b exp %b", i, rsp3, exp); end
        end
        cyc;
    endtask

    initial begin
        test_reset;
        test_contention;
        test_single_write;
        test_read;
        test_back_to_back;
        test_reset_during_issue;
        test_three_skip;
        repeat (2) cyc;
        n_chk++; if (mon_err !== 0) begin n_fail++; $display("FAIL monitor_errors got %0d exp 0", mon_err); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
